// File: rtl/pattern_player_pkg.sv
// Shared definitions for the pattern player and the input-capture block:
// key encoding, FSM states and the key-to-lamp decode.
package pattern_player_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned MAX_KEYS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StGap,
        StDone
    } state_e;

    // Keys 1..MAX_KEYS light lamp (key-1); anything else is dark.
    function automatic logic [MAX_KEYS-1:0] key_to_onehot(input logic [KEY_W-1:0] key);
        logic [MAX_KEYS-1:0] oh;
        oh = '0;
        if (key != '0 && key <= KEY_W'(MAX_KEYS)) begin
            oh = MAX_KEYS'(1) << (key - KEY_W'(1));
        end
        return oh;
    endfunction

endpackage

// File: rtl/pattern_player_step_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module step_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Plays up to eight latched keys on a one-hot lamp bank: each key lit for
// ON_CYCLES, then dark for GAP_CYCLES, followed by a one-cycle done pulse.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 50_000_000,
    parameter int unsigned GAP_CYCLES = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [KEY_W*MAX_KEYS-1:0] target_seq,
    input  logic [3:0]                difficulty_k,
    output logic [MAX_KEYS-1:0]       led,
    output logic [KEY_W-1:0]          show_key,
    output logic                      key_strobe,
    output logic [3:0]                play_idx,
    output logic                      play_active,
    output logic                      play_done
);

    localparam int unsigned MaxCycles = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
    // Timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad = TimerW'(GAP_CYCLES - 1);

    state_e                    state_q, state_d;
    logic [KEY_W*MAX_KEYS-1:0] seq_q, seq_d;
    logic [3:0]                keff_q, keff_d;
    logic [3:0]                idx_q, idx_d;
    logic [MAX_KEYS-1:0]       led_q, led_d;
    logic [KEY_W-1:0]          show_key_q, show_key_d;
    logic                      strobe_q, strobe_d;
    logic                      active_q, active_d;
    logic                      done_q, done_d;

    logic              tmr_load, tmr_en, tmr_tc;
    logic [TimerW-1:0] tmr_val;
    logic [3:0]        k_clamp, idx_inc;
    logic [KEY_W-1:0]  nxt_key;

    assign k_clamp = (difficulty_k > 4'(MAX_KEYS)) ? 4'(MAX_KEYS) : difficulty_k;
    assign idx_inc = idx_q + 4'd1;
    assign nxt_key = seq_q[{idx_inc[2:0], 2'b00} +: KEY_W];

    step_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .en_i      (tmr_en),
        .tc_o      (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        keff_d     = keff_q;
        idx_d      = idx_q;
        led_d      = led_q;
        show_key_d = show_key_q;
        strobe_d   = 1'b0;
        active_d   = active_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    seq_d  = target_seq;
                    keff_d = k_clamp;
                    idx_d  = '0;
                    if (k_clamp == '0) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        led_d    = '0;
                    end else begin
                        state_d    = StOn;
                        led_d      = key_to_onehot(target_seq[KEY_W-1:0]);
                        show_key_d = target_seq[KEY_W-1:0];
                        strobe_d   = 1'b1;
                        active_d   = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = OnLoad;
                    end
                end
            end
            StOn: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d  = StGap;
                    led_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = GapLoad;
                end
            end
            StGap: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    if (idx_inc == keff_q) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        state_d    = StOn;
                        idx_d      = idx_inc;
                        led_d      = key_to_onehot(nxt_key);
                        show_key_d = nxt_key;
                        strobe_d   = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = OnLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a start seen in the same cycle.
        if (abort) begin
            state_d  = StIdle;
            led_d    = '0;
            active_d = 1'b0;
            done_d   = 1'b0;
            strobe_d = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            seq_q      <= '0;
            keff_q     <= '0;
            idx_q      <= '0;
            led_q      <= '0;
            show_key_q <= '0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            keff_q     <= keff_d;
            idx_q      <= idx_d;
            led_q      <= led_d;
            show_key_q <= show_key_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign led         = led_q;
    assign show_key    = show_key_q;
    assign key_strobe  = strobe_q;
    assign play_idx    = idx_q;
    assign play_active = active_q;
    assign play_done   = done_q;

endmodule
